control_unit: RTL and testbench
===============================

Name: control_unit

Overview:
- Multi-cycle control unit that drives the 32-register datapath: fetches, decodes and sequences instructions.
- Generates every datapath control strobe: register addresses, mux selects, FU function select, immediate and link value.
- Owns the PC, the instruction register (IR) and a latched status register (C,V,N,Z) used for branches.
- Handshakes with instruction memory and data memory through req/ack strobes.

Parameters:
- SIZE, 32, datapath width. Register-address width is $clog2(SIZE); supported range 16..32.
- SEL_ADD, 4'b0010, FU Sel code for A+B. Used for load/store effective address.
- SEL_PASSA, 4'b0000, FU Sel code for F=A. Used by JR.

Ports:
- clk  in  1  clock.
- reset  in  1  synchronous, active-high.
- instr_in  in  32  instruction word from instruction memory.
- imem_ack  in  1  instr_in valid this cycle.
- dmem_ack  in  1  data memory completes current read/write this cycle.
- C, V, N, Z  in  1 each  datapath FU flags (combinational).
- Addr_in  in  SIZE  datapath Addr_out. Used as the JR target.
- imem_req  out  1  instruction fetch request.
- PC_out  out  SIZE  current PC; instruction memory address.
- Link_out  out  SIZE  PC+1; goes to datapath PC_in.
- we, MuxB_sel, MuxD_sel, MuxR_sel  out  1 each  datapath controls.
- Sel  out  4  FU function select.
- AA, BA, DA  out  $clog2(SIZE)  register addresses.
- Constant_in  out  SIZE  sign-extended imm16.
- dmem_rd, dmem_wr  out  1 each  data memory strobes.
- halted  out  1  high in HALT state.

Behaviour:
- Encoding: op=IR[31:26], d=IR[25:21], a=IR[20:16], b=IR[15:11], imm16=IR[15:0]. Register fields are truncated to $clog2(SIZE) bits.
- Constant_in is always sext(imm16) to SIZE.
- Reset:
  - Takes effect on the clock edge.
  - PC=0, IR=0, flags=0, state=FETCH.
  - All strobes 0 (we, dmem_rd, dmem_wr, halted). Selects 0.
  - Reset aborts any pending memory access.
- States: FETCH, EXEC, MEM, HALT.
- FETCH:
  - imem_req=1 and PC_out=PC.
  - When imem_ack: IR<=instr_in, go to EXEC.
  - we, dmem_rd, dmem_wr stay 0 throughout.
- EXEC (one cycle), by op:
  - 0x00-0x0F ALU reg: Sel=op[3:0], MuxB=0, MuxD=1, MuxR=1, we=1, DA=d, AA=a, BA=b. Flags<=C,V,N,Z. PC+1.
  - 0x10-0x1F ALU imm: same as ALU reg except MuxB=1. Flags are updated.
  - 0x20 LD: Sel=SEL_ADD, MuxB=1, AA=a, dmem_rd=1. Go to MEM.
  - 0x21 ST: Sel=SEL_ADD, MuxB=1, AA=a, BA=d (source register), dmem_wr=1. Go to MEM.
  - 0x30 BZ, 0x31 BN, 0x32 BC, 0x33 BV: test the latched flag. Taken → PC<=PC+1+sext(imm16); not taken → PC+1.
  - 0x34 JMP: unconditional relative jump, PC<=PC+1+sext(imm16).
  - 0x35 JAL: we=1, MuxR=0, DA=d (R[d]<=Link_out). PC<=PC+1+sext(imm16).
  - 0x36 JR: Sel=SEL_PASSA, AA=a, PC<=Addr_in.
  - 0x3F: go to HALT.
  - Any other op is a NOP: PC+1.
  - Branch, JR and NOP ops have we=0.
- Every non-HALT op returns to FETCH after completing.
- MEM:
  - Controls (Sel, MuxB, AA, BA, Constant_in, strobe) are held stable until dmem_ack.
  - LD: in the ack cycle, we=1, MuxD=0, MuxR=1, DA=d.
  - On ack: strobe drops next cycle, PC+1, go to FETCH.
  - There is no timeout.
- Flags are updated only by ALU-class ops. LD/ST address arithmetic never updates them.
- PC arithmetic is modulo 2^SIZE; 0xFFFFFFFF+1 wraps to 0.
- HALT: halted=1, all strobes 0. Exit only by reset.
- Latency with same-cycle ack: ALU/branch/jump = 2 cycles; LD/ST = 3 + memory wait cycles.

Test Plan:
- ADDI R1,R0,5 (0x48200005), ack same cycle:
  - FETCH→EXEC.
  - EXEC shows we=1, MuxB=1, MuxD=1, MuxR=1, Sel=2, DA=1, AA=0, Constant_in=5.
  - PC 0→1.
- BZ -2 (0xC000FFFE) at PC=4:
  - Latched Z=1 → PC=3.
  - Latched Z=0 → PC=5.
  - Flags must come from the prior ALU op, not from the live Z input.
- LD R2,8(R1) (0x80410008), dmem_ack after 3 cycles:
  - dmem_rd held high with Sel=2, Constant_in=8.
  - we=1, MuxD=0 only in the ack cycle.
  - No write before the ack cycle; PC+1.
- JAL R31,+16 (0xD7E00010) at PC=10: Link_out=11, we=1, MuxR=0, DA=31, next PC=27.
- HALT (0xFC000000): halted=1 and imem_req=0 indefinitely. Reset → PC=0, FETCH, halted=0.
- Reset asserted during the MEM wait of a load: next edge dmem_rd=0, we=0, PC=0, state FETCH. No register write occurs.

Source files
------------

// File: rtl/control_unit.sv
// control_unit: multi-cycle fetch/decode/sequence controller that drives the 32-register datapath.
module control_unit #(
    parameter int SIZE = 32,
    parameter logic [3:0] SEL_ADD = 4'b0010,
    parameter logic [3:0] SEL_PASSA = 4'b0000
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [31:0]              instr_in,
    input  logic                     imem_ack,
    input  logic                     dmem_ack,
    input  logic                     C,
    input  logic                     V,
    input  logic                     N,
    input  logic                     Z,
    input  logic [SIZE-1:0]          Addr_in,
    output logic                     imem_req,
    output logic [SIZE-1:0]          PC_out,
    output logic [SIZE-1:0]          Link_out,
    output logic                     we,
    output logic                     MuxB_sel,
    output logic                     MuxD_sel,
    output logic                     MuxR_sel,
    output logic [3:0]               Sel,
    output logic [$clog2(SIZE)-1:0]  AA,
    output logic [$clog2(SIZE)-1:0]  BA,
    output logic [$clog2(SIZE)-1:0]  DA,
    output logic [SIZE-1:0]          Constant_in,
    output logic                     dmem_rd,
    output logic                     dmem_wr,
    output logic                     halted
);
    localparam int AW = $clog2(SIZE);
    typedef enum logic [1:0] {FETCH, EXEC, MEM, HALT} state_t;
    state_t state;
    logic [31:0] ir;
    logic [SIZE-1:0] pc, pc_inc, imm, target;
    logic [3:0] flags;
    logic [5:0] op;
    logic [AW-1:0] fd, fa, fb;
    logic alu, ld, st, jal, jr, taken, exec, mem, mem_op, ld_wb, alu_x;
    assign op = ir[31:26];
    assign fd = ir[21 +: AW];
    assign fa = ir[16 +: AW];
    assign fb = ir[11 +: AW];
    assign imm = SIZE'($signed(ir[15:0]));
    assign pc_inc = pc + SIZE'(1);
    assign alu = ~op[5];
    assign ld = op == 6'h20;
    assign st = op == 6'h21;
    assign jal = op == 6'h35;
    assign jr = op == 6'h36;
    // flags are held as {V,C,N,Z} so op[1:0] of BZ/BN/BC/BV indexes the tested bit directly
    assign taken = (op == 6'h34) | jal | ((op[5:2] == 4'b1100) & flags[op[1:0]]);
    assign target = jr ? Addr_in : taken ? pc_inc + imm : pc_inc;
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= FETCH;
            pc <= '0;
            ir <= '0;
            flags <= '0;
        end else begin
            case (state)
                FETCH: if (imem_ack) begin
                    ir <= instr_in;
                    state <= EXEC;
                end
                EXEC: begin
                    if (alu) flags <= {V, C, N, Z};
                    if (ld | st) state <= MEM;
                    else if (op == 6'h3F) state <= HALT;
                    else begin
                        pc <= target;
                        state <= FETCH;
                    end
                end
                MEM: if (dmem_ack) begin
                    pc <= pc_inc;
                    state <= FETCH;
                end
                default: ;
            endcase
        end
    end
    assign exec = state == EXEC;
    assign mem = state == MEM;
    assign alu_x = exec & alu;
    // load/store controls stay up from EXEC through the whole memory wait
    assign mem_op = (exec | mem) & (ld | st);
    assign ld_wb = mem & ld & dmem_ack;
    assign imem_req = state == FETCH;
    assign halted = state == HALT;
    assign PC_out = pc;
    assign Link_out = pc_inc;
    assign Constant_in = imm;
    assign Sel = alu_x ? op[3:0] : (exec & jr) ? SEL_PASSA : mem_op ? SEL_ADD : 4'b0;
    assign MuxB_sel = (alu_x & op[4]) | mem_op;
    assign MuxD_sel = alu_x;
    assign MuxR_sel = alu_x | ld_wb;
    assign we = alu_x | (exec & jal) | ld_wb;
    assign DA = (alu_x | (exec & jal) | ld_wb) ? fd : '0;
    assign AA = (alu_x | (exec & jr) | mem_op) ? fa : '0;
    assign BA = alu_x ? fb : (mem_op & st) ? fd : '0;
    assign dmem_rd = mem_op & ld;
    assign dmem_wr = mem_op & st;
endmodule

// File: tb/tb_control_unit.sv
// tb_control_unit: directed test-plan cases plus randomized run against an instruction-level model.
module tb_control_unit;
    logic clk = 0, reset = 1;
    logic [31:0] instr_in = 0;
    logic imem_ack = 0, dmem_ack = 0, C = 0, V = 0, N = 0, Z = 0;
    logic [31:0] Addr_in = 0;
    logic imem_req, we, MuxB_sel, MuxD_sel, MuxR_sel, dmem_rd, dmem_wr, halted;
    logic [31:0] PC_out, Link_out, Constant_in;
    logic [3:0] Sel;
    logic [4:0] AA, BA, DA;
    int n_checks = 0, n_err = 0;
    bit chk_en = 0;

    control_unit dut (
        .clk(clk), .reset(reset), .instr_in(instr_in), .imem_ack(imem_ack), .dmem_ack(dmem_ack),
        .C(C), .V(V), .N(N), .Z(Z), .Addr_in(Addr_in), .imem_req(imem_req), .PC_out(PC_out),
        .Link_out(Link_out), .we(we), .MuxB_sel(MuxB_sel), .MuxD_sel(MuxD_sel), .MuxR_sel(MuxR_sel),
        .Sel(Sel), .AA(AA), .BA(BA), .DA(DA), .Constant_in(Constant_in), .dmem_rd(dmem_rd),
        .dmem_wr(dmem_wr), .halted(halted)
    );

    always #5 clk = ~clk;

    // Instruction-level model: phase 0 waiting for instruction, 1 executing, 2 waiting on memory, 3 halted
    int m_ph = 0;
    logic [31:0] m_pc = 0, m_ir = 0;
    bit m_z, m_n, m_c, m_v, jump;
    int mop;
    longint off;

    always @(posedge clk) begin
        if (reset) begin
            m_ph = 0; m_pc = 0; m_ir = 0;
            m_z = 0; m_n = 0; m_c = 0; m_v = 0;
        end else if (m_ph == 0) begin
            if (imem_ack) begin m_ir = instr_in; m_ph = 1; end
        end else if (m_ph == 1) begin
            mop = int'(m_ir[31:26]);
            off = longint'($signed(m_ir[15:0]));
            m_ph = 0;
            if (mop < 32) begin
                m_z = Z; m_n = N; m_c = C; m_v = V;
                m_pc = m_pc + 1;
            end else if (mop == 32 || mop == 33) m_ph = 2;
            else if (mop == 63) m_ph = 3;
            else if (mop == 54) m_pc = Addr_in;
            else begin
                jump = (mop == 52 || mop == 53) || (mop == 48 && m_z) || (mop == 49 && m_n) ||
                       (mop == 50 && m_c) || (mop == 51 && m_v);
                m_pc = 32'(longint'(m_pc) + 1 + (jump ? off : 0));
            end
        end else if (m_ph == 2) begin
            if (dmem_ack) begin m_pc = m_pc + 1; m_ph = 0; end
        end
    end

    logic e_req, e_halt, e_rd, e_wr, e_we, e_mb, e_md, e_mr;
    logic [3:0] e_sel;
    logic [4:0] e_aa, e_ba, e_da, fd, fa, fb;
    logic [5:0] eop;
    logic [122:0] got, exp_v;

    always @(negedge clk) begin
        if (chk_en) begin
            eop = m_ir[31:26]; fd = m_ir[25:21]; fa = m_ir[20:16]; fb = m_ir[15:11];
            e_req = m_ph == 0; e_halt = m_ph == 3;
            {e_rd, e_wr, e_we, e_mb, e_md, e_mr, e_sel, e_aa, e_ba, e_da} = '0;
            if (m_ph == 1) begin
                if (eop < 6'd32) begin
                    e_we = 1; e_mb = eop >= 6'd16; e_md = 1; e_mr = 1;
                    e_sel = eop[3:0]; e_da = fd; e_aa = fa; e_ba = fb;
                end else if (eop == 6'h20 || eop == 6'h21) begin
                    e_sel = 4'd2; e_mb = 1; e_aa = fa;
                    if (eop == 6'h20) e_rd = 1; else begin e_wr = 1; e_ba = fd; end
                end else if (eop == 6'h35) begin
                    e_we = 1; e_da = fd;
                end else if (eop == 6'h36) e_aa = fa;
            end else if (m_ph == 2) begin
                e_sel = 4'd2; e_mb = 1; e_aa = fa;
                if (eop == 6'h20) begin
                    e_rd = 1;
                    if (dmem_ack) begin e_we = 1; e_mr = 1; e_da = fd; end
                end else begin e_wr = 1; e_ba = fd; end
            end
            got = {imem_req, halted, dmem_rd, dmem_wr, we, MuxB_sel, MuxD_sel, MuxR_sel, Sel, AA, BA, DA,
                   PC_out, Link_out, Constant_in};
            exp_v = {e_req, e_halt, e_rd, e_wr, e_we, e_mb, e_md, e_mr, e_sel, e_aa, e_ba, e_da,
                     m_pc, m_pc + 32'd1, 32'(longint'($signed(m_ir[15:0])))};
            n_checks++;
            if (got !== exp_v) begin
                n_err++;
                $display("FAIL cycle_outputs t=%0t: got %h expected %h", $time, got, exp_v);
            end
        end
    end

    task automatic chk(input string nm, input logic [63:0] g, input logic [63:0] e);
        n_checks++;
        if (g !== e) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", nm, g, e);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic fetch(input logic [31:0] w);
        imem_ack = 1; instr_in = w;
        tick();
        imem_ack = 0;
    endtask

    function automatic logic [31:0] rand_instr();
        int r = $urandom_range(0, 99);
        logic [5:0] op;
        logic [25:0] f = 26'($urandom());
        if (r < 35) op = 6'($urandom_range(0, 15));
        else if (r < 55) op = 6'($urandom_range(16, 31));
        else if (r < 65) op = 6'h20;
        else if (r < 73) op = 6'h21;
        else if (r < 85) op = 6'($urandom_range(48, 51));
        else if (r < 89) op = 6'h34;
        else if (r < 92) op = 6'h35;
        else if (r < 95) op = 6'h36;
        else if (r < 97) op = 6'h3F;
        else op = 6'($urandom_range(34, 47));
        return {op, f};
    endfunction

    localparam logic [31:0] NOP = 32'h8800_0000;

    initial begin
        tick();
        chk_en = 1;
        tick();
        #3;
        chk("reset_pc", PC_out, 0);
        chk("reset_fetch", {imem_req, halted, we, dmem_rd, dmem_wr}, 5'b10000);
        reset = 0;
        // ADDI R1,R0,5 with live Z=1 so the latched Z becomes 1
        Z = 1;
        fetch(32'h4820_0005);
        #3;
        chk("addi_ctl", {we, MuxB_sel, MuxD_sel, MuxR_sel, Sel}, {4'b1111, 4'd2});
        chk("addi_regs", {DA, AA}, {5'd1, 5'd0});
        chk("addi_const", Constant_in, 5);
        tick();
        #3;
        chk("addi_pc", PC_out, 1);
        Z = 0;
        repeat (3) begin fetch(NOP); tick(); end
        fetch(32'hC000_FFFE);
        tick();
        #3;
        chk("bz_taken_pc", PC_out, 3);
        fetch(32'h0000_0000);
        tick();
        Z = 1;
        fetch(32'hC000_FFFE);
        tick();
        #3;
        chk("bz_not_taken_pc", PC_out, 5);
        Z = 0;
        // LD R2,8(R1) with a three-cycle memory wait
        fetch(32'h8041_0008);
        #3;
        chk("ld_exec", {dmem_rd, we, Sel}, {2'b10, 4'd2});
        chk("ld_const", Constant_in, 8);
        repeat (2) begin
            tick();
            #3;
            chk("ld_wait", {dmem_rd, we, MuxB_sel, Sel}, {3'b101, 4'd2});
        end
        tick();
        dmem_ack = 1;
        #3;
        chk("ld_ack", {dmem_rd, we, MuxD_sel, MuxR_sel, DA}, {4'b1101, 5'd2});
        tick();
        dmem_ack = 0;
        #3;
        chk("ld_done", {dmem_rd, we, imem_req}, 3'b001);
        chk("ld_pc", PC_out, 6);
        repeat (4) begin fetch(NOP); tick(); end
        fetch(32'hD7E0_0010);
        #3;
        chk("jal_link", Link_out, 11);
        chk("jal_ctl", {we, MuxR_sel, DA}, {2'b10, 5'd31});
        tick();
        #3;
        chk("jal_pc", PC_out, 27);
        // reset during the memory wait of a load
        fetch(32'h8041_0008);
        tick();
        reset = 1;
        tick();
        reset = 0;
        #3;
        chk("rst_mem_strobes", {dmem_rd, we, imem_req}, 3'b001);
        chk("rst_mem_pc", PC_out, 0);
        // JR to the top of the address space, then PC+1 wraps to zero
        Addr_in = 32'hFFFF_FFFF;
        fetch(32'hD800_0000);
        tick();
        #3;
        chk("jr_pc", PC_out, 32'hFFFF_FFFF);
        chk("jr_link_wrap", Link_out, 0);
        fetch(NOP);
        tick();
        #3;
        chk("pc_wrap", PC_out, 0);
        fetch(32'hFC00_0000);
        tick();
        #3;
        chk("halt", {halted, imem_req}, 2'b10);
        repeat (5) tick();
        #3;
        chk("halt_stays", {halted, imem_req, we}, 3'b100);
        reset = 1;
        tick();
        reset = 0;
        #3;
        chk("halt_reset", {halted, imem_req}, 2'b01);
        chk("halt_reset_pc", PC_out, 0);
        repeat (4000) begin
            tick();
            reset = ($urandom_range(0, 299) == 0) || (m_ph == 3 && $urandom_range(0, 5) == 0);
            imem_ack = $urandom_range(0, 3) != 0;
            instr_in = rand_instr();
            dmem_ack = $urandom_range(0, 2) == 0;
            {C, V, N, Z} = 4'($urandom());
            Addr_in = $urandom();
        end
        tick();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end
endmodule
